// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: D/E/M register-use fields, exception strobes,
// and the stall/flush/clear outputs with the performance counters.
interface pipe_hazard_ctrl_if;
   logic [4:0]  rsD;
   logic [4:0]  rtD;
   logic [1:0]  tuse_rsD;
   logic [1:0]  tuse_rtD;
   logic [4:0]  waE;
   logic [1:0]  tnewE;
   logic [4:0]  waM;
   logic [1:0]  tnewM;
   logic        md_useD;
   logic        md_startE;
   logic        md_divE;
   logic        exc_M;
   logic        eret_M;
   logic        stallFD;
   logic        Eclr;
   logic        DEMWclr;
   logic        md_busy;
   logic [31:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output rsD, rtD, tuse_rsD, tuse_rtD, waE, tnewE, waM, tnewM,
             md_useD, md_startE, md_divE, exc_M, eret_M,
      input  stallFD, Eclr, DEMWclr, md_busy, stall_cnt, flush_cnt
   );

   modport slave (
      input  rsD, rtD, tuse_rsD, tuse_rtD, waE, tnewE, waM, tnewM,
             md_useD, md_startE, md_divE, exc_M, eret_M,
      output stallFD, Eclr, DEMWclr, md_busy, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: Tuse/Tnew register hazards,
// multiply/divide busy tracking, exception/ERET flush arbitration, perf counters.
module pipe_hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10   // cnt is 4 bits, so at most 15
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2
   } md_state_t;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

   md_state_t   state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] stall_cnt_reg;
   logic [15:0] flush_cnt_reg;

   logic [1:0][4:0] src;
   logic [1:0][1:0] tuse;
   logic [1:0]      haz;
   logic            md_busy_int;
   logic            md_haz;
   logic            stall_raw;
   logic            flush_raw;
   logic            stall_int;
   logic            flush_int;

   assign src[0]  = bus.rsD;
   assign src[1]  = bus.rtD;
   assign tuse[0] = bus.tuse_rsD;
   assign tuse[1] = bus.tuse_rtD;

   // Stall only when a producer is strictly later than the consumer's deadline;
   // equal times are covered by the forwarding network.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign haz[gi] = (src[gi] != 5'd0) && (tuse[gi] != 2'd3) &&
                          (((bus.waE == src[gi]) && (bus.tnewE > tuse[gi])) ||
                           ((bus.waM == src[gi]) && (bus.tnewM > tuse[gi])));
      end
   endgenerate

   assign md_busy_int = (state_reg != IDLE);
   assign md_haz      = bus.md_useD && (bus.md_startE || md_busy_int);
   assign stall_raw   = haz[0] || haz[1] || md_haz;
   assign flush_raw   = bus.exc_M || bus.eret_M;

   assign flush_int = !rst && flush_raw;
   assign stall_int = !rst && stall_raw && !flush_raw;

   assign bus.stallFD   = stall_int;
   assign bus.Eclr      = stall_int;
   assign bus.DEMWclr   = flush_int;
   assign bus.md_busy   = md_busy_int;
   assign bus.stall_cnt = stall_cnt_reg;
   assign bus.flush_cnt = flush_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         stall_cnt_reg <= 32'd0;
         flush_cnt_reg <= 16'd0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         stall_cnt_reg <= stall_cnt_reg + {31'd0, stall_int};
         flush_cnt_reg <= flush_cnt_reg + {15'd0, flush_int};
      end
   end

   // A running operation has already committed past E, so a flush only blocks a new start.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (bus.md_startE && !flush_raw) begin
               state_next = bus.md_divE ? DIV : MULT;
               cnt_next   = bus.md_divE ? DIV_LOAD : MULT_LOAD;
            end
         end
         MULT, DIV: begin
            if (cnt_reg == 4'd0) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each step queues its expected outputs
// and compares them mid-cycle against the DUT.
module tb_pipe_hazard_ctrl;
   localparam int MC = 5;
   localparam int DC = 10;

   typedef struct {
      string       tag;
      logic        stall;
      logic        flush;
      logic        busy;
      logic [31:0] stall_cnt;
      logic [15:0] flush_cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];
   logic [31:0] model_stall_cnt;
   logic [15:0] model_flush_cnt;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   task automatic idle_in();
      bus.rsD = 5'd0;  bus.rtD = 5'd0;
      bus.tuse_rsD = 2'd3; bus.tuse_rtD = 2'd3;
      bus.waE = 5'd0;  bus.tnewE = 2'd0;
      bus.waM = 5'd0;  bus.tnewM = 2'd0;
      bus.md_useD = 1'b0; bus.md_startE = 1'b0; bus.md_divE = 1'b0;
      bus.exc_M = 1'b0;   bus.eret_M = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   // Pop the oldest expectation and compare it with what the DUT shows now.
   task automatic compare();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty got 0 exp 1");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ":stallFD"},   {31'd0, bus.stallFD}, {31'd0, e.stall});
      chk({e.tag, ":Eclr"},      {31'd0, bus.Eclr},    {31'd0, e.stall});
      chk({e.tag, ":DEMWclr"},   {31'd0, bus.DEMWclr}, {31'd0, e.flush});
      chk({e.tag, ":md_busy"},   {31'd0, bus.md_busy}, {31'd0, e.busy});
      chk({e.tag, ":stall_cnt"}, bus.stall_cnt,        e.stall_cnt);
      chk({e.tag, ":flush_cnt"}, {16'd0, bus.flush_cnt}, {16'd0, e.flush_cnt});
      $display("step %-16s stall=%0b flush=%0b busy=%0b scnt=%0d fcnt=%0d",
               e.tag, bus.stallFD, bus.DEMWclr, bus.md_busy, bus.stall_cnt, bus.flush_cnt);
   endtask

   // One clock cycle: inputs already applied; expected outputs for this cycle given.
   task automatic step(input string tag, input logic stall, input logic flush, input logic busy);
      exp_t e;
      e.tag       = tag;
      e.stall     = stall;
      e.flush     = flush;
      e.busy      = busy;
      e.stall_cnt = model_stall_cnt;
      e.flush_cnt = model_flush_cnt;
      sb.push_back(e);
      @(negedge clk);
      compare();
      if (rst) begin
         model_stall_cnt = 32'd0;
         model_flush_cnt = 16'd0;
      end else begin
         model_stall_cnt = model_stall_cnt + {31'd0, stall};
         model_flush_cnt = model_flush_cnt + {15'd0, flush};
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_stall_cnt = 32'd0;
      model_flush_cnt = 16'd0;
      idle_in();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      idle_in(); step("reset_state", 0, 0, 0);

      // load-use: lw in E, add reading rs in D
      idle_in(); bus.rsD = 5'd1; bus.tuse_rsD = 2'd1; bus.waE = 5'd1; bus.tnewE = 2'd2;
      step("lw_use_E", 1, 0, 0);
      idle_in(); bus.rsD = 5'd1; bus.tuse_rsD = 2'd1; bus.waM = 5'd1; bus.tnewM = 2'd1;
      step("lw_use_M", 0, 0, 0);

      idle_in(); bus.rsD = 5'd0; bus.tuse_rsD = 2'd0; bus.waE = 5'd0; bus.tnewE = 2'd2;
      step("reg_zero", 0, 0, 0);
      idle_in(); bus.rsD = 5'd5; bus.tuse_rsD = 2'd3; bus.waE = 5'd5; bus.tnewE = 2'd2;
      step("rs_unused", 0, 0, 0);
      idle_in(); bus.rtD = 5'd7; bus.tuse_rtD = 2'd0; bus.waM = 5'd7; bus.tnewM = 2'd1;
      step("rt_haz_M", 1, 0, 0);
      idle_in(); bus.rsD = 5'd4; bus.tuse_rsD = 2'd1; bus.waE = 5'd4; bus.tnewE = 2'd1;
      step("equal_fwd", 0, 0, 0);

      // mult in E, mflo in D
      idle_in(); bus.md_startE = 1'b1; bus.md_useD = 1'b1;
      step("mult_start", 1, 0, 0);
      for (int i = 1; i <= MC; i++) begin
         idle_in(); bus.md_useD = 1'b1;
         step($sformatf("mult_busy%0d", i), 1, 0, 1);
      end
      idle_in(); bus.md_useD = 1'b1;
      step("mult_done", 0, 0, 0);

      // div in E, mflo in D
      idle_in(); bus.md_startE = 1'b1; bus.md_divE = 1'b1; bus.md_useD = 1'b1;
      step("div_start", 1, 0, 0);
      for (int i = 1; i <= DC; i++) begin
         idle_in(); bus.md_useD = 1'b1;
         step($sformatf("div_busy%0d", i), 1, 0, 1);
      end
      idle_in(); bus.md_useD = 1'b1;
      step("div_done", 0, 0, 0);

      // flush overrides a live hazard
      idle_in(); bus.rsD = 5'd3; bus.tuse_rsD = 2'd0; bus.waE = 5'd3; bus.tnewE = 2'd2; bus.exc_M = 1'b1;
      step("haz_exc", 0, 1, 0);
      idle_in(); bus.exc_M = 1'b1; bus.eret_M = 1'b1;
      step("exc_eret", 0, 1, 0);
      idle_in(); step("after_flush", 0, 0, 0);

      // exception during a divide does not abort it
      idle_in(); bus.md_startE = 1'b1; bus.md_divE = 1'b1;
      step("div2_start", 0, 0, 0);
      for (int i = 1; i <= DC; i++) begin
         idle_in();
         if (i == 3) bus.exc_M = 1'b1;
         step($sformatf("div2_busy%0d", i), 0, (i == 3), 1);
      end
      idle_in(); step("div2_done", 0, 0, 0);

      // flush blocks a new start
      idle_in(); bus.md_startE = 1'b1; bus.exc_M = 1'b1;
      step("start_exc", 0, 1, 0);
      idle_in(); step("start_exc_next", 0, 0, 0);

      // reset in the middle of a divide
      idle_in(); bus.md_startE = 1'b1; bus.md_divE = 1'b1;
      step("div3_start", 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         idle_in(); step($sformatf("div3_busy%0d", i), 0, 0, 1);
      end
      idle_in(); bus.md_useD = 1'b1; rst = 1'b1;
      step("rst_haz", 0, 0, 1);
      idle_in(); bus.exc_M = 1'b1; bus.rsD = 5'd2; bus.tuse_rsD = 2'd0; bus.waE = 5'd2; bus.tnewE = 2'd2;
      step("rst_exc", 0, 0, 0);
      rst = 1'b0;
      idle_in(); step("post_rst", 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage exception-capable MIPS pipeline. It compares operand-use deadlines of the instruction in D against result-ready times of the instructions in E and M, tracks the multi-cycle multiply/divide unit, and arbitrates between hazard stalls and exception/ERET flushes. Its outputs drive the F/D hold enables and the clear inputs of the D/E, E/M and M/W pipeline registers (`Eclr`, `DEMWclr`). It also keeps two free-running performance counters.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu leaves E
- DIV_CYC, 10, busy cycles after a div/divu leaves E; must be ≤15 (4-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rsD  in  5  rs field of instruction in D
- rtD  in  5  rt field of instruction in D
- tuse_rsD  in  2  cycles until D needs rs (0..2); 3 = rs not read
- tuse_rtD  in  2  cycles until D needs rt (0..2); 3 = rt not read
- waE  in  5  destination register of instruction in E (0 = none)
- tnewE  in  2  cycles until E result is forwardable (0..2)
- waM  in  5  destination register of instruction in M (0 = none)
- tnewM  in  2  cycles until M result is forwardable (0..1)
- md_useD  in  1  D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_startE  in  1  E holds a mult/multu/div/divu
- md_divE  in  1  with md_startE: 1 = divide, 0 = multiply
- exc_M  in  1  exception or interrupt taken at M this cycle
- eret_M  in  1  eret in M this cycle
- stallFD  out  1  hold PC and the F/D register
- Eclr  out  1  insert a bubble into the D/E register
- DEMWclr  out  1  flush the D/E, E/M and M/W registers
- md_busy  out  1  multiply/divide unit busy (registered)
- stall_cnt  out  32  cycles with stallFD=1
- flush_cnt  out  16  cycles with DEMWclr=1

## Operation
- Register hazard, per source s ∈ {rs, rt}: haz_s = (s≠0) & (tuse_sD≠3) & [ (waE==s & tnewE>tuse_sD) | (waM==s & tnewM>tuse_sD) ]. Equal deadlines are resolved by forwarding and do not stall.
- MD hazard: md_haz = md_useD & (md_startE | md_busy).
- Raw stall: stall_raw = haz_rs | haz_rt | md_haz.
- Flush: DEMWclr = exc_M | eret_M. The flush overrides every stall, so stallFD = stall_raw & ~DEMWclr and Eclr = stallFD.
- MD state machine, states IDLE/MULT/DIV with 4-bit down-counter cnt:
  - IDLE → MULT with cnt=MULT_CYC-1 when md_startE & ~md_divE & ~DEMWclr.
  - IDLE → DIV with cnt=DIV_CYC-1 when md_startE & md_divE & ~DEMWclr.
  - In MULT/DIV: decrement cnt every cycle. When cnt==0, go to IDLE.
  - A flush does not abort an operation already in MULT/DIV; that instruction has already committed past E.
  - md_startE while not IDLE cannot occur, because md_haz holds the instruction in D.
- md_busy = (state≠IDLE).
- stall_cnt increments when stallFD=1; flush_cnt increments when DEMWclr=1. Both wrap modulo 2^width.

## Timing
- stallFD, Eclr and DEMWclr are combinational from the inputs and the current state, with no added latency.
- While rst=1, all three are forced to 0.
- Synchronous reset: state=IDLE, cnt=0, md_busy=0, stall_cnt=0, flush_cnt=0. Reset applied mid-operation aborts a busy MULT/DIV immediately.
- Multiply busy window: md_startE in cycle t gives md_busy=1 in cycles t+1..t+MULT_CYC and 0 in t+MULT_CYC+1. Divide is the same with DIV_CYC.
- An md_useD instruction directly behind a mult stalls for cycles t..t+MULT_CYC, i.e. MULT_CYC+1 cycles.
- exc_M and eret_M both high: single flush, flush_cnt +1.
- exc_M together with md_startE: the MD unit does not start (md_busy stays 0).

## Test plan
- lw $1 in E (waE=1, tnewE=2) with add reading rs=1 (tuse_rsD=1) in D → stallFD=Eclr=1 for that cycle; next cycle with waM=1, tnewM=1 → no stall; stall_cnt=1.
- rsD=0, waE=0, tnewE=2, tuse_rsD=0 → no stall (register $0 exempt). Same with tuse_rsD=3 and waE=rsD=5 → no stall.
- mult in E (md_startE=1, md_divE=0) followed by mflo in D → stallFD=1 for 6 cycles; md_busy=1 for exactly 5 cycles; repeat with div → 11 stall cycles, 10 busy.
- Hazard stall active (waE=rsD=3, tnewE=2, tuse_rsD=0) with exc_M=1 in the same cycle → DEMWclr=1, stallFD=0, Eclr=0; flush_cnt=1, stall_cnt unchanged.
- div started, exc_M pulse at busy cycle 3 → md_busy stays 1 through cycle 10. Then md_startE with exc_M in the same cycle → md_busy stays 0.
- rst asserted at busy cycle 4 of a div → next cycle md_busy=0, both counters 0, and outputs are 0 while rst=1.
